nios2e_ram_arbiter: RTL

//  Shares the single-port 4096x32 on-chip RAM between two Avalon-MM masters:
//  m0 (Nios II data master) and m1 (PWM/motor-log capture engine).

---
 rtl/nios2e_ram_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/nios2e_ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between two Avalon-MM masters,
// with bounded read-modify-write locking and fixed 1-cycle read data return.
module nios2e_ram_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic                m0_lock,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic                m1_lock,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic        LOCK_EN = (LOCK_MAX > 1);

  typedef enum logic [1:0] {ST_ARB, ST_LOCK0, ST_LOCK1} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic                last_grant_q, last_grant_d;
  logic                rd_pend_q, rd_pend_d;
  logic                rd_owner_q, rd_owner_d;
  logic [ADDR_W-1:0]   addr_hold_q, addr_hold_d;

  logic req0, req1, grant0, grant1, accept, sel_read, sel_write, sel_lock, own_lock;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_ARB;
      lock_cnt_q   <= '0;
      last_grant_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= 1'b0;
      addr_hold_q  <= '0;
    end else begin
      state_q      <= state_d;
      lock_cnt_q   <= lock_cnt_d;
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
      addr_hold_q  <= addr_hold_d;
    end
  end

  // Grant selection: round-robin in ARB, exclusive to the lock owner otherwise.
  always_comb begin
    req0   = m0_read | m0_write;
    req1   = m1_read | m1_write;
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (state_q)
      ST_ARB: begin
        if (req0 && req1) begin
          grant0 = last_grant_q;
          grant1 = ~last_grant_q;
        end else begin
          grant0 = req0;
          grant1 = req1;
        end
      end
      ST_LOCK0: grant0 = req0;
      ST_LOCK1: grant1 = req1;
      default: ;
    endcase
    accept    = grant0 | grant1;
    sel_write = grant1 ? m1_write : (grant0 & m0_write);
    sel_read  = grant1 ? (m1_read & ~m1_write) : (grant0 & m0_read & ~m0_write);
    sel_lock  = grant1 ? m1_lock : (grant0 & m0_lock);
    own_lock  = (state_q == ST_LOCK1) ? m1_lock : m0_lock;
  end

  // Next state, lock counting and read-return tracking.
  always_comb begin
    state_d      = state_q;
    lock_cnt_d   = lock_cnt_q;
    last_grant_d = accept ? grant1 : last_grant_q;
    rd_pend_d    = sel_read;
    rd_owner_d   = accept ? grant1 : rd_owner_q;
    addr_hold_d  = ram_address;
    unique case (state_q)
      ST_ARB: begin
        if (accept && sel_lock && LOCK_EN) begin
          state_d    = grant1 ? ST_LOCK1 : ST_LOCK0;
          lock_cnt_d = CNT_W'(1);
        end
      end
      ST_LOCK0, ST_LOCK1: begin
        if (accept && (lock_cnt_q != CNT_W'(LOCK_MAX)))
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
        if (!own_lock || (lock_cnt_d == CNT_W'(LOCK_MAX))) begin
          state_d    = ST_ARB;
          lock_cnt_d = '0;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // RAM port mux; address holds its last value while idle.
  always_comb begin
    ram_clken      = 1'b1;
    ram_chipselect = accept;
    ram_write      = sel_write;
    ram_address    = addr_hold_q;
    ram_byteenable = '0;
    ram_writedata  = '0;
    if (grant1) begin
      ram_address    = m1_address;
      ram_writedata  = m1_writedata;
      ram_byteenable = m1_write ? m1_byteenable : {BE_W{1'b1}};
    end else if (grant0) begin
      ram_address    = m0_address;
      ram_writedata  = m0_writedata;
      ram_byteenable = m0_write ? m0_byteenable : {BE_W{1'b1}};
    end
  end

  assign m0_waitrequest   = req0 & ~grant0;
  assign m1_waitrequest   = req1 & ~grant1;
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;
  assign m0_readdatavalid = rd_pend_q & ~rd_owner_q;
  assign m1_readdatavalid = rd_pend_q & rd_owner_q;

endmodule
